iq_frame_source: RTL and testbench
==================================

Name: iq_frame_source

Overview:
- Upstream producer for the arithmetic/decoder chain. Builds signed i, q and u frames from a raw ADC stream and hands them over with a valid/ready handshake.
- ADC stream is sampled at 4x the carrier. Per sample, the block applies quadrature products (+1,0,-1,0 / 0,+1,0,-1), accumulates over a programmable frame length, and presents each finished frame.
- Output registers are separate from the accumulators (double-buffered), so accumulation runs while the consumer is still processing the previous frame.

Parameters:
- CLK_REF, 50_000_000, system clock frequency in Hz.
- SAMPL_T, 1_760_000, ADC sample rate in Hz; must equal 4*FRQ_SIGNAL.
- FRQ_SIGNAL, 440_000, carrier frequency in Hz (documentation and assertion only).
- T, CLK_REF/SAMPL_T (integer-truncated, 28), clocks per sample strobe; must be >= 2.
- ACC_LEN_DEF, 64, frame length in samples after reset.

Ports:
- clk  in  1  system clock.
- reset_l  in  1  asynchronous, active-low reset.
- clk_en  in  1  global clock enable; when low, all state is frozen.
- enable  in  1  run control.
- adc_data  in  16  signed ADC sample; sampled on the strobe.
- wr_en  in  1  register write strobe.
- address  in  3  register address: 0 = ACC_LEN, 1 = CTRL.
- wr_data  in  32  register write data.
- i_o  out  32  signed in-phase sum.
- q_o  out  32  signed quadrature sum.
- u_o  out  32  signed magnitude sum (always >= 0).
- frame_valid  out  1  frame present on i_o/q_o/u_o.
- frame_ready  in  1  consumer accepts the frame.
- overrun  out  1  sticky flag: a frame was dropped.
- frame_cnt  out  16  count of accepted frames; wraps.

Behaviour:
- Reset values: i_o = q_o = u_o = 0, frame_valid = 0, overrun = 0, frame_cnt = 0, acc_len = ACC_LEN_DEF. Prescaler, phase, sample count and accumulators all reset to 0.
- clk_en = 0: no register changes anywhere, including handshake and register writes.
- Prescaler: counts 0..T-1 while enable = 1. strobe = 1 for one clk when count == T-1. enable = 0 clears prescaler, phase, sample count and accumulators; the output slot and frame_valid are held.
- Per strobe, by phase (2-bit, wraps 3 -> 0):
  - phase 0: acc_i += x
  - phase 1: acc_q += x
  - phase 2: acc_i -= x
  - phase 3: acc_q -= x
  - every phase: acc_u += |x|
- Arithmetic: x is sign-extended to 32 bits. |(-32768)| = 32768. No saturation is needed: |sum| <= 32768 * 65535 < 2^31.
- Frame end: on the strobe where sample_cnt == acc_len-1, at the same edge:
  - the slot loads (acc + current contribution);
  - frame_valid <= 1;
  - accumulators, sample_cnt and phase <= 0.
  - Latency from the last strobe to frame_valid = 1 clk edge.
- Handshake:
  - A transfer occurs on an edge where frame_valid && frame_ready.
  - The edge after a transfer sees frame_valid = 0, unless a new frame loads on the same edge.
  - On a transfer, frame_cnt increments (65535 -> 0).
  - Outputs are stable while frame_valid = 1 and frame_ready = 0.
- Frame end coinciding with a transfer: the new frame loads, frame_valid stays 1, no overrun.
- Frame end while frame_valid = 1 and frame_ready = 0: the new frame is discarded, the old slot is held, overrun <= 1, accumulation restarts normally.
- ACC_LEN register (address 0):
  - Written value uses wr_data[15:0] with bits [1:0] forced to 0.
  - Results < 4 are clamped to 4.
  - The write is held pending and takes effect at the next frame boundary or when enable = 0.
- CTRL register (address 1): wr_data[0] = 1 clears overrun. A set and a clear on the same edge resolve to set.
- Other addresses: writes are ignored. There is no read path.
- Reset mid-frame: all state returns to reset values immediately, and any pending frame is lost.
- FSM:
  - IDLE (enable = 0) -> ACCUM on enable = 1.
  - ACCUM -> IDLE on enable = 0.
  - The output slot is a separate EMPTY/FULL bit (= frame_valid).

Decomposition:
- Package iq_src_pkg:
  - ADDR_ACC_LEN = 3'd0, ADDR_CTRL = 3'd1.
  - Phase enum PH_IP, PH_QP, PH_IN, PH_QN.
  - State enum IDLE/ACCUM.
  - ACC_W = 32, ADC_W = 16.
- Sub-module sample_strobe_gen (prescaler with parameter T, inputs clk_en and enable, output strobe).

Test Plan:
- acc_len = 4, adc_data = 1000 constant -> after 4 strobes: i_o = 0, q_o = 0, u_o = 4000, frame_valid = 1 exactly 1 clk after the 4th strobe; strobe spacing = 28 clk.
- acc_len = 8, adc sequence 100, 0, -100, 0 repeated, frame_ready = 1 -> i_o = 400, q_o = 0, u_o = 400; frame_cnt increments by 1 per frame.
- acc_len = 4, sequence -32768, 0, 32767, 0 -> i_o = -65535, q_o = 0, u_o = 65535 (checks width and abs edge).
- frame_ready = 0 across two frame ends -> overrun = 1; i_o/q_o/u_o hold the first frame. Write CTRL = 1 -> overrun = 0. Frame end on the same cycle as a transfer -> overrun stays 0.
- Write ACC_LEN = 6 mid-frame -> current frame still uses 64 samples; next frames use 4; a write of 1 gives 4.
- Deassert reset_l mid-frame with frame_valid = 1 -> all outputs 0 immediately. clk_en = 0 for 100 clk -> prescaler and outputs unchanged.

Source files
------------

// File: rtl/iq_src_pkg.sv
// Shared types and constants for the IQ frame source: register map, phase and
// run-state encodings, datapath widths.
package iq_src_pkg;

   localparam int ACC_W = 32;
   localparam int ADC_W = 16;

   localparam logic [2:0] ADDR_ACC_LEN = 3'd0;
   localparam logic [2:0] ADDR_CTRL    = 3'd1;

   typedef enum logic [1:0] {PH_IP, PH_QP, PH_IN, PH_QN} phase_t;
   typedef enum logic {IDLE, ACCUM} state_t;

   // Frame length is a whole number of carrier periods (multiple of 4), minimum one period.
   function automatic logic [15:0] clamp_len(input logic [15:0] v);
      logic [15:0] l;
      l = {v[15:2], 2'b00};
      if (l < 16'd4) l = 16'd4;
      return l;
   endfunction

endpackage

// File: rtl/sample_strobe_gen.sv
// Prescaler producing a one-clock sample strobe every T clocks while enabled.
module sample_strobe_gen #(
   parameter int T = 28
) (
   input  logic clk,
   input  logic reset_l,
   input  logic clk_en,
   input  logic enable,
   output logic strobe
);

   localparam int CW = $clog2(T);
   localparam logic [CW-1:0] LAST = CW'(T - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         cnt <= '0;
      end else if (clk_en) begin
         if (!enable || cnt == LAST) cnt <= '0;
         else                        cnt <= cnt + 1'b1;
      end
   end

   assign strobe = clk_en && enable && (cnt == LAST);

endmodule

// File: rtl/iq_frame_source.sv
// Quadrature demodulating frame builder: accumulates i/q/|x| sums over a
// programmable number of ADC samples and hands each frame over valid/ready.
module iq_frame_source
   import iq_src_pkg::*;
#(
   parameter int CLK_REF     = 50_000_000,
   parameter int SAMPL_T     = 1_760_000,
   parameter int FRQ_SIGNAL  = 440_000,
   parameter int T           = CLK_REF / SAMPL_T,
   parameter int ACC_LEN_DEF = 64
) (
   input  logic                    clk,
   input  logic                    reset_l,
   input  logic                    clk_en,
   input  logic                    enable,
   input  logic signed [ADC_W-1:0] adc_data,
   input  logic                    wr_en,
   input  logic [2:0]              address,
   input  logic [31:0]             wr_data,
   output logic signed [ACC_W-1:0] i_o,
   output logic signed [ACC_W-1:0] q_o,
   output logic signed [ACC_W-1:0] u_o,
   output logic                    frame_valid,
   input  logic                    frame_ready,
   output logic                    overrun,
   output logic [15:0]             frame_cnt,
   output state_t                  dbg_state
);

   localparam bit PARAMS_OK = (SAMPL_T == 4 * FRQ_SIGNAL) && (T >= 2);

   // Handshake: a frame moves on every enabled edge with frame_valid && frame_ready;
   // i_o/q_o/u_o hold while frame_valid is high and frame_ready is low.

   state_t state, next_state;
   logic   acc_clear;
   logic   strobe;

   phase_t                  phase;
   logic [15:0]             sample_cnt, acc_len, pend_len;
   logic                    pend_valid;
   logic signed [ACC_W-1:0] acc_i, acc_q, acc_u;
   logic signed [ACC_W-1:0] x, abs_x, sum_i, sum_q, sum_u;
   logic                    frame_end, xfer, load, drop, apply_len;
   logic                    wr_acc_len, wr_ctrl;
   logic                    unused_wr_bits;

   sample_strobe_gen #(.T(T)) u_strobe (
      .clk     (clk),
      .reset_l (reset_l),
      .clk_en  (clk_en),
      .enable  (enable),
      .strobe  (strobe)
   );

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l)    state <= IDLE;
      else if (clk_en) state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (enable)  next_state = ACCUM;
         ACCUM:   if (!enable) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      acc_clear = (next_state == IDLE);
      dbg_state = state;
   end

   assign x     = {{(ACC_W-ADC_W){adc_data[ADC_W-1]}}, adc_data};
   assign abs_x = adc_data[ADC_W-1] ? -x : x;

   always_comb begin
      sum_i = acc_i;
      sum_q = acc_q;
      case (phase)
         PH_IP:   sum_i = acc_i + x;
         PH_QP:   sum_q = acc_q + x;
         PH_IN:   sum_i = acc_i - x;
         PH_QN:   sum_q = acc_q - x;
         default: ;
      endcase
      sum_u = acc_u + abs_x;
   end

   assign frame_end  = strobe && (sample_cnt == acc_len - 16'd1);
   assign xfer       = frame_valid && frame_ready;
   assign load       = frame_end && (!frame_valid || frame_ready);
   assign drop       = frame_end && frame_valid && !frame_ready;
   assign wr_acc_len = wr_en && (address == ADDR_ACC_LEN);
   assign wr_ctrl    = wr_en && (address == ADDR_CTRL);
   assign apply_len  = pend_valid && (frame_end || acc_clear);
   assign unused_wr_bits = ^wr_data[31:16];

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         phase      <= PH_IP;
         sample_cnt <= '0;
         acc_i      <= '0;
         acc_q      <= '0;
         acc_u      <= '0;
      end else if (clk_en) begin
         if (acc_clear || frame_end) begin
            phase      <= PH_IP;
            sample_cnt <= '0;
            acc_i      <= '0;
            acc_q      <= '0;
            acc_u      <= '0;
         end else if (strobe) begin
            phase      <= phase_t'(phase + 2'd1);
            sample_cnt <= sample_cnt + 16'd1;
            acc_i      <= sum_i;
            acc_q      <= sum_q;
            acc_u      <= sum_u;
         end
      end
   end

   // A new length only takes effect between frames so a running frame keeps its size.
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         acc_len    <= 16'(ACC_LEN_DEF);
         pend_len   <= 16'(ACC_LEN_DEF);
         pend_valid <= 1'b0;
      end else if (clk_en) begin
         if (apply_len) begin
            acc_len    <= pend_len;
            pend_valid <= 1'b0;
         end
         if (wr_acc_len) begin
            pend_len   <= clamp_len(wr_data[15:0]);
            pend_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         i_o         <= '0;
         q_o         <= '0;
         u_o         <= '0;
         frame_valid <= 1'b0;
         frame_cnt   <= '0;
         overrun     <= 1'b0;
      end else if (clk_en) begin
         if (load) begin
            i_o <= sum_i;
            q_o <= sum_q;
            u_o <= sum_u;
         end
         if (load)      frame_valid <= 1'b1;
         else if (xfer) frame_valid <= 1'b0;
         if (xfer) frame_cnt <= frame_cnt + 16'd1;
         if (drop)                      overrun <= 1'b1;
         else if (wr_ctrl && wr_data[0]) overrun <= 1'b0;
      end
   end

   a_params_ok: assert property (@(posedge clk) PARAMS_OK);

endmodule

// File: tb/tb_iq_frame_source.sv
// Directed bench for iq_frame_source: a table of single-frame vectors plus
// hand-written sequences for overrun, pending length, reset and clock-enable.
module tb_iq_frame_source;
   import iq_src_pkg::*;

   localparam int TS = 28;

   logic               clk = 1'b0;
   logic               reset_l, clk_en, enable, wr_en, frame_ready;
   logic signed [15:0] adc_data;
   logic [2:0]         address;
   logic [31:0]        wr_data;
   logic signed [31:0] i_o, q_o, u_o;
   logic               frame_valid, overrun;
   logic [15:0]        frame_cnt;
   state_t             dbg_state;

   int          n_total = 0;
   int          n_pass  = 0;
   logic [15:0] exp_cnt;
   logic        pfv, pov;

   typedef struct packed {
      logic [31:0]      len_wr;
      logic [3:0][15:0] seq;
      logic [15:0]      n_samp;
      logic [31:0]      ei, eq, eu;
   } vec_t;

   vec_t vecs [8];

   always #5 clk = ~clk;

   iq_frame_source dut (
      .clk         (clk),
      .reset_l     (reset_l),
      .clk_en      (clk_en),
      .enable      (enable),
      .adc_data    (adc_data),
      .wr_en       (wr_en),
      .address     (address),
      .wr_data     (wr_data),
      .i_o         (i_o),
      .q_o         (q_o),
      .u_o         (u_o),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .overrun     (overrun),
      .frame_cnt   (frame_cnt),
      .dbg_state   (dbg_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
   endtask

   function automatic vec_t mk(input logic [31:0] l, input int s0, input int s1, input int s2,
                               input int s3, input int n, input int ei, input int eq, input int eu);
      vec_t v;
      v.len_wr = l;
      v.seq[0] = 16'(s0);
      v.seq[1] = 16'(s1);
      v.seq[2] = 16'(s2);
      v.seq[3] = 16'(s3);
      v.n_samp = 16'(n);
      v.ei = 32'(ei);
      v.eq = 32'(eq);
      v.eu = 32'(eu);
      return v;
   endfunction

   task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
      address = a;
      wr_data = d;
      wr_en   = 1'b1;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   // Each sample spans exactly TS negedges, matching the prescaler period from a
   // negedge where enable rose with the prescaler at zero.
   task automatic run_samples(input int n, input logic [3:0][15:0] seq, input bit ready_last,
                              output logic o_fv, output logic o_ov);
      o_fv = 1'b0;
      o_ov = 1'b0;
      for (int k = 0; k < n; k++) begin
         adc_data = seq[k % 4];
         @(negedge clk);
         wr_en = 1'b0;
         repeat (TS - 2) @(negedge clk);
         if (k == n - 1) begin
            o_fv = frame_valid;
            o_ov = overrun;
            if (ready_last) frame_ready = 1'b1;
         end
         @(negedge clk);
         if (k == n - 1 && ready_last) frame_ready = 1'b0;
      end
   endtask

   initial begin
      logic [3:0][15:0] s;
      reset_l = 1'b0; clk_en = 1'b1; enable = 1'b0; wr_en = 1'b0;
      address = '0; wr_data = '0; frame_ready = 1'b0; adc_data = '0;
      exp_cnt = '0;

      vecs[0] = mk(32'd4,          1000,   1000,   1000,  1000,  4,      0,   0, 4000);
      vecs[1] = mk(32'd8,           100,      0,   -100,     0,  8,    400,   0,  400);
      vecs[2] = mk(32'd4,        -32768,      0,  32767,     0,  4, -65535,   0, 65535);
      vecs[3] = mk(32'd4,             5,     -7,      3,    11,  4,      2, -18,   26);
      vecs[4] = mk(32'd12,         -200,    300,     50,   -25, 12,   -750, 975, 1725);
      vecs[5] = mk(32'd1,            10,     20,     30,    40,  4,    -20, -20,  100);
      vecs[6] = mk(32'd6,             1,      2,      4,     8,  4,     -3,  -6,   15);
      vecs[7] = mk(32'hFFFF_0013,     7,      7,      7,     7, 16,      0,   0,  112);

      repeat (2) @(negedge clk);
      check("reset_i", i_o, 0);
      check("reset_q", q_o, 0);
      check("reset_u", u_o, 0);
      check("reset_valid", 32'(frame_valid), 0);
      check("reset_overrun", 32'(overrun), 0);
      check("reset_cnt", 32'(frame_cnt), 0);
      check("reset_state", 32'(dbg_state), 32'(IDLE));
      reset_l = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         write_reg(ADDR_ACC_LEN, vecs[v].len_wr);
         @(negedge clk);
         enable = 1'b1;
         run_samples(int'(vecs[v].n_samp), vecs[v].seq, 1'b0, pfv, pov);
         check($sformatf("v%0d_valid_before_last", v), 32'(pfv), 0);
         check($sformatf("v%0d_valid", v), 32'(frame_valid), 1);
         check($sformatf("v%0d_i", v), i_o, vecs[v].ei);
         check($sformatf("v%0d_q", v), q_o, vecs[v].eq);
         check($sformatf("v%0d_u", v), u_o, vecs[v].eu);
         check($sformatf("v%0d_state", v), 32'(dbg_state), 32'(ACCUM));
         frame_ready = 1'b1;
         @(negedge clk);
         frame_ready = 1'b0;
         exp_cnt++;
         check($sformatf("v%0d_valid_after_xfer", v), 32'(frame_valid), 0);
         check($sformatf("v%0d_cnt", v), 32'(frame_cnt), 32'(exp_cnt));
         enable = 1'b0;
         @(negedge clk);
      end

      // Overrun, clear, then a frame end coinciding with a transfer.
      write_reg(ADDR_ACC_LEN, 32'd4);
      @(negedge clk);
      enable = 1'b1;
      s = {16'd1, 16'd1, 16'd1, 16'd1};
      run_samples(4, s, 1'b0, pfv, pov);
      check("ovr_first_u", u_o, 4);
      s = {16'd2, 16'd2, 16'd2, 16'd2};
      run_samples(4, s, 1'b0, pfv, pov);
      check("ovr_before_drop", 32'(pov), 0);
      check("ovr_set", 32'(overrun), 1);
      check("ovr_hold_u", u_o, 4);
      check("ovr_hold_i", i_o, 0);
      check("ovr_hold_valid", 32'(frame_valid), 1);
      address = ADDR_CTRL; wr_data = 32'd1; wr_en = 1'b1;
      s = {16'd3, 16'd3, 16'd3, 16'd3};
      run_samples(4, s, 1'b1, pfv, pov);
      exp_cnt++;
      check("ctrl_clear", 32'(pov), 0);
      check("coincide_valid", 32'(frame_valid), 1);
      check("coincide_u", u_o, 12);
      check("coincide_overrun", 32'(overrun), 0);
      check("coincide_cnt", 32'(frame_cnt), 32'(exp_cnt));

      // Asynchronous reset in the middle of a frame with a frame held.
      s = {16'd5, 16'd5, 16'd5, 16'd5};
      run_samples(2, s, 1'b0, pfv, pov);
      #2 reset_l = 1'b0;
      #1;
      check("mid_reset_i", i_o, 0);
      check("mid_reset_q", q_o, 0);
      check("mid_reset_u", u_o, 0);
      check("mid_reset_valid", 32'(frame_valid), 0);
      check("mid_reset_cnt", 32'(frame_cnt), 0);
      exp_cnt = '0;
      enable = 1'b0;
      @(negedge clk);
      reset_l = 1'b1;
      @(negedge clk);

      // Length written mid-frame applies from the next frame; 6 rounds down to 4.
      enable = 1'b1;
      s = {16'd1, 16'd1, 16'd1, 16'd1};
      run_samples(10, s, 1'b0, pfv, pov);
      address = ADDR_ACC_LEN; wr_data = 32'd6; wr_en = 1'b1;
      run_samples(54, s, 1'b0, pfv, pov);
      check("len64_valid_before_last", 32'(pfv), 0);
      check("len64_valid", 32'(frame_valid), 1);
      check("len64_u", u_o, 64);
      frame_ready = 1'b1;
      s = {16'd8, 16'd4, 16'd2, 16'd1};
      run_samples(4, s, 1'b0, pfv, pov);
      frame_ready = 1'b0;
      exp_cnt++;
      check("len4_valid_before_last", 32'(pfv), 0);
      check("len4_valid", 32'(frame_valid), 1);
      check("len4_i", i_o, -3);
      check("len4_q", q_o, -6);
      check("len4_u", u_o, 15);
      check("len4_cnt", 32'(frame_cnt), 32'(exp_cnt));

      // Clock enable low freezes everything, including handshake, writes and enable.
      s = {16'd1, 16'd1, 16'd1, 16'd1};
      run_samples(2, s, 1'b0, pfv, pov);
      clk_en = 1'b0; frame_ready = 1'b1; enable = 1'b0;
      address = ADDR_ACC_LEN; wr_data = 32'd100; wr_en = 1'b1;
      repeat (100) @(negedge clk);
      check("clken_valid", 32'(frame_valid), 1);
      check("clken_cnt", 32'(frame_cnt), 32'(exp_cnt));
      check("clken_u", u_o, 15);
      check("clken_state", 32'(dbg_state), 32'(ACCUM));
      clk_en = 1'b1; frame_ready = 1'b0; enable = 1'b1; wr_en = 1'b0;
      run_samples(2, s, 1'b0, pfv, pov);
      check("clken_no_early_drop", 32'(pov), 0);
      check("clken_drop_on_time", 32'(overrun), 1);
      check("clken_hold_u", u_o, 15);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
